// File: rtl/io_pkg.sv
// io_pkg
// Shared constants for the board I/O conditioning front end.
//   SW_WIDTH_DEF        : width of the raw switch bank
//   DEBOUNCE_CYCLES_DEF : button settle time in clk cycles (1 ms at 100 MHz)
//   DEBOUNCE_CYCLES_SIM : short settle time used for simulation builds
package io_pkg;

  localparam int SW_WIDTH_DEF        = 16;
  localparam int DEBOUNCE_CYCLES_DEF = 100_000;
  localparam int DEBOUNCE_CYCLES_SIM = 8;

endpackage : io_pkg

// File: rtl/button_debouncer.sv
// button_debouncer
// Synchronizes one raw, asynchronous, active-high button into the clk domain,
// debounces it and emits a single-cycle pulse on each accepted press.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronized samples needed to accept
//                     a level change (must be >= 2)
// Ports:
//   clk     in  : system clock, rising edge
//   reset   in  : asynchronous, active-high; clears every flop
//   btn_i   in  : raw button input, asynchronous to clk
//   level_o out : debounced button level (registered)
//   pulse_o out : one-cycle pulse on the edge where level_o goes 0->1
module button_debouncer
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer; sync_q2 is the only copy the debouncer looks at.
  logic sync_q1;
  logic sync_q2;

  // Debouncer state.
  logic          stable_q;
  logic [CW-1:0] count_q;
  logic          pulse_q;

  logic          stable_d;
  logic [CW-1:0] count_d;
  logic          pulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_i;
      sync_q2 <= sync_q1;
    end
  end

  // A disagreement between the synchronized sample and the accepted level
  // must persist for DEBOUNCE_CYCLES consecutive samples. Any sample that
  // agrees with stable_q (a bounce back) throws the partial count away.
  always_comb begin
    stable_d = stable_q;
    count_d  = '0;
    pulse_d  = 1'b0;
    if (sync_q2 != stable_q) begin
      if (count_q == CNT_MAX) begin
        stable_d = sync_q2;
        count_d  = '0;
        // Only the press direction produces an event.
        pulse_d  = sync_q2;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      count_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;

endmodule : button_debouncer

// File: rtl/input_conditioner.sv
// input_conditioner
// Front end between the board pins and processor_top. Buttons are
// synchronized, debounced and turned into single-cycle press pulses; the
// switch bank is only synchronized (no debounce, no glitch filtering).
// Every output comes straight from a flop.
//
// Parameters:
//   DEBOUNCE_CYCLES : button settle time in clk cycles (>= 2)
//   SW_WIDTH        : switch bus width
// Ports:
//   clk              in  : system clock, rising edge
//   reset            in  : asynchronous, active-high
//   run_i            in  : raw Run button
//   continue_i       in  : raw Continue button
//   sw_i             in  : raw switch bank [SW_WIDTH]
//   run_level_o      out : debounced Run level
//   run_pulse_o      out : one-cycle pulse per accepted Run press
//   continue_level_o out : debounced Continue level
//   continue_pulse_o out : one-cycle pulse per accepted Continue press
//   sw_o             out : synchronized switches [SW_WIDTH]
module input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SW_WIDTH        = SW_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_i,
  input  logic                continue_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                run_level_o,
  output logic                run_pulse_o,
  output logic                continue_level_o,
  output logic                continue_pulse_o,
  output logic [SW_WIDTH-1:0] sw_o
);

  // Per-bit two-flop synchronizer. Bits are not coherent with each other
  // while a switch is moving; software reads a settled bank.
  logic [SW_WIDTH-1:0] sw_sync_q1;
  logic [SW_WIDTH-1:0] sw_sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync_q1 <= '0;
      sw_sync_q2 <= '0;
    end else begin
      sw_sync_q1 <= sw_i;
      sw_sync_q2 <= sw_sync_q1;
    end
  end

  assign sw_o = sw_sync_q2;

  // The two buttons share nothing but clock and reset.
  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (run_i),
    .level_o (run_level_o),
    .pulse_o (run_pulse_o)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_continue_db (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (continue_i),
    .level_o (continue_level_o),
    .pulse_o (continue_pulse_o)
  );

endmodule : input_conditioner

// File: doc/input_conditioner.md
# input_conditioner

Front-end conditioning stage between the board I/O pins and `processor_top`. It synchronizes the `run_i`/`continue_i` buttons and the 16 `sw_i` switches into the `clk` domain and debounces both buttons. It also produces single-cycle rising-edge pulses, so the processor's control FSM sees exactly one run/continue event per physical press.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000: consecutive stable synchronized samples required to accept a button level change (1 ms at 100 MHz); legal range ≥ 2.
- `SW_WIDTH`, default 16: switch bus width.

- `clk`  in  1: single system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately on assertion.
- `run_i`  in  1: raw Run button, active-high, asynchronous to `clk`.
- `continue_i`  in  1: raw Continue button, active-high, asynchronous to `clk`.
- `sw_i`  in  SW_WIDTH: raw switch bank.
- `run_level_o`  out  1: debounced Run level.
- `run_pulse_o`  out  1: one-cycle pulse on debounced Run 0→1.
- `continue_level_o`  out  1: debounced Continue level.
- `continue_pulse_o`  out  1: one-cycle pulse on debounced Continue 0→1.
- `sw_o`  out  SW_WIDTH: synchronized switches.

## Operation
- Every input passes through a 2-flop synchronizer, and all synchronizer flops reset to 0.
- Switches are synchronized only. `sw_o` is the second flop, with no debounce and no glitch filtering.
- Each button has its own debouncer: `stable` (1 bit) and `count` (width `$clog2(DEBOUNCE_CYCLES)`).
  - Synced value == `stable`: `count` ← 0.
  - Synced value != `stable` and `count` < DEBOUNCE_CYCLES-1: `count` ← `count`+1.
  - Synced value != `stable` and `count` == DEBOUNCE_CYCLES-1: `stable` ← synced value, `count` ← 0.
- A bounce, meaning a return to the `stable` value before the threshold, restarts the count from 0. There is no partial credit.
- The pulse is registered: `pulse_o` ← 1 in the same clock edge where `stable` goes 0→1, and 0 on every other edge. Release (1→0) never pulses.
- `level_o` is `stable` directly.
- The two buttons are fully independent. Simultaneous presses yield both pulses, each in its own correct cycle, possibly the same cycle.
- Reset mid-debounce discards `count`. After release, debouncing restarts from `stable`=0.
- A button held through reset release is treated as a new press: after reset deasserts, a pulse follows once the full debounce latency elapses.

## Timing
- Reset values: all outputs 0; all `count`=0; all `stable`=0.
- Switch latency: a change sampled at edge k appears on `sw_o` after edge k+1 (2 edges).
- Button press latency: synced value first differs at edge k+1. `stable` and `pulse_o` go high after edge k+1+DEBOUNCE_CYCLES. That is 2+DEBOUNCE_CYCLES edges after the raw input is first sampled high.
- `pulse_o` width is exactly 1 cycle regardless of how long the button is held.
- Release latency is the same as press latency; `level_o` falls with no pulse.
- Minimum re-press: a new pulse requires release debounce plus press debounce, i.e. at least 2·DEBOUNCE_CYCLES cycles of stable levels.
- Outputs are registered, with no combinational path from input to output.

## Structure
- Package `io_pkg`: `SW_WIDTH_DEF` = 16, `DEBOUNCE_CYCLES_DEF` = 100_000, `DEBOUNCE_CYCLES_SIM` = 8.
- Sub-module `button_debouncer` (parameter DEBOUNCE_CYCLES; ports `clk`, `reset`, `btn_i`, `level_o`, `pulse_o`) contains the 2-flop sync, counter, stable flop and pulse flop. It is instantiated twice.
- The top level holds the switch synchronizer array.
- `processor_top` instantiates this block and consumes `run_pulse_o`, `continue_pulse_o` and `sw_o` in place of the raw pins.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8.
- Reset: `reset`=1 for 20 cycles with `run_i`=1 and `sw_i`=16'h005a → all outputs 0 during reset. After release, `sw_o`=16'h005a after 2 edges, and `run_pulse_o` is high for exactly 1 cycle at edge 10.
- Clean press: `run_i` 0→1, held for 10 cycles → `run_pulse_o` high for exactly one cycle, 10 edges after the first high sample. `run_level_o` stays 1 until 10 edges after release, and release produces no pulse.
- Bounce: `continue_i` toggles 1,0,1,0 on alternate cycles for 12 cycles, then is held at 1 → no pulse during toggling, then one pulse 10 edges after the final rise.
- Short glitch: `run_i`=1 for 5 cycles, then 0 → `run_level_o` and `run_pulse_o` never assert.
- Simultaneous: both buttons rise on the same edge and are held for 20 cycles → both pulses fire in the same cycle, once each. Switch change 16'h0003→16'h0004 is reflected on `sw_o` 2 edges later.
- Reset mid-debounce: `run_i` rises, and `reset` is pulsed at count=5 → no pulse, and a fresh full 10-edge latency is measured from reset release.
